// File: rtl/access_pkg.sv
// ============================================================================
//  Module      : access_pkg
//  Description : Shared state encoding, default parameters and helpers for the
//                access controller with lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package access_pkg;

    localparam int c_DIGIT_W     = 4;
    localparam int c_PW_LEN      = 4;
    localparam int c_ROM_LAT     = 2;
    localparam int c_MAX_TRIES   = 3;
    localparam int c_LOCK_CYCLES = 1000;
    localparam int c_NUM_PLAYERS = 2;

    // Stored password 3,5,9,1 with digit 0 in the least significant nibble
    localparam logic [c_PW_LEN*c_DIGIT_W-1:0] c_PW_INIT = 16'h1953;

    typedef enum logic [3:0] {
        ST_DIGIT     = 4'd0,
        ST_ROMWAIT   = 4'd1,
        ST_COMPARE   = 4'd2,
        ST_ADVANCE   = 4'd3,
        ST_PWCHECK   = 4'd4,
        ST_LOCKOUT   = 4'd5,
        ST_PASSED    = 4'd6,
        ST_RECONFIG  = 4'd7,
        ST_GAMEWAIT  = 4'd8,
        ST_GAMESTART = 4'd9,
        ST_GAMEOVER  = 4'd10
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/access_controller_lockout_if.sv
// ============================================================================
//  Module      : access_controller_lockout_if
//  Description : Keypad, game-control and status bundle of the access
//                controller. master = stimulus side, slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface access_controller_lockout_if #(
    parameter int DIGIT_W     = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_TRIES   = 3
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    logic                   pwButton;
    logic [DIGIT_W-1:0]     pw;
    logic [NUM_PLAYERS-1:0] loadP;
    logic                   finalTimeout;
    logic [NUM_PLAYERS-1:0] loadPPass;
    logic                   GR;
    logic                   RD;
    logic                   reconfig;
    logic                   timerEnable;
    logic                   locked;
    logic [TRIES_W-1:0]     triesLeft;

    modport master (
        output pwButton, pw, loadP, finalTimeout,
        input  loadPPass, GR, RD, reconfig, timerEnable, locked, triesLeft
    );

    modport slave (
        input  pwButton, pw, loadP, finalTimeout,
        output loadPPass, GR, RD, reconfig, timerEnable, locked, triesLeft
    );

endinterface

`default_nettype wire

// File: rtl/pw_rom.sv
// ============================================================================
//  Module      : pw_rom
//  Description : Password ROM of PW_LEN digits with ROM_LAT registered stages
//                between address and data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pw_rom
    import access_pkg::*;
#(
    parameter int DIGIT_W = c_DIGIT_W,
    parameter int PW_LEN  = c_PW_LEN,
    parameter int ROM_LAT = c_ROM_LAT,
    parameter logic [PW_LEN*DIGIT_W-1:0] PW_INIT = c_PW_INIT
) (
    input  logic                         clk,
    input  logic [addr_w(PW_LEN)-1:0]    addr,
    output logic [DIGIT_W-1:0]           data
);

    logic [DIGIT_W-1:0] w_word;
    logic [DIGIT_W-1:0] r_stage [ROM_LAT];

    assign w_word = PW_INIT[addr*DIGIT_W +: DIGIT_W];

    for (genvar i = 0; i < ROM_LAT; i++) begin : g_stage
        if (i == 0) begin : g_first
            always_ff @(posedge clk) r_stage[i] <= w_word;
        end else begin : g_next
            always_ff @(posedge clk) r_stage[i] <= r_stage[i-1];
        end
    end

    assign data = r_stage[ROM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/access_controller_lockout.sv
// ============================================================================
//  Module      : access_controller_lockout
//  Description : Password entry with try counter and timed lockout, followed
//                by a reconfigure / game start / game over control sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module access_controller_lockout
    import access_pkg::*;
#(
    parameter int DIGIT_W     = c_DIGIT_W,
    parameter int PW_LEN      = c_PW_LEN,
    parameter int ROM_LAT     = c_ROM_LAT,
    parameter int MAX_TRIES   = c_MAX_TRIES,
    parameter int LOCK_CYCLES = c_LOCK_CYCLES,
    parameter int NUM_PLAYERS = c_NUM_PLAYERS,
    parameter logic [PW_LEN*DIGIT_W-1:0] PW_INIT = c_PW_INIT
) (
    input  logic                          clk,
    input  logic                          rst,
    access_controller_lockout_if.slave    bus
);

    localparam int AW      = addr_w(PW_LEN);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int WC_W    = $clog2(ROM_LAT + 1);
    localparam int LC_W    = $clog2(LOCK_CYCLES + 1);

    state_t                 r_state;
    logic [AW-1:0]          r_addr;
    logic                   r_match;
    logic [TRIES_W-1:0]     r_tries;
    logic                   r_gr;
    logic                   r_rd;
    logic                   r_locked;
    logic                   r_reconfig;
    logic                   r_timer_en;
    logic [NUM_PLAYERS-1:0] r_load_pass;
    logic [LC_W-1:0]        r_lock_cnt;
    logic [WC_W-1:0]        r_wait_cnt;
    logic [DIGIT_W-1:0]     r_digit;
    logic [DIGIT_W-1:0]     r_rom_q;
    logic [DIGIT_W-1:0]     w_rom_data;

    pw_rom #(
        .DIGIT_W (DIGIT_W),
        .PW_LEN  (PW_LEN),
        .ROM_LAT (ROM_LAT),
        .PW_INIT (PW_INIT)
    ) u_pw_rom (
        .clk  (clk),
        .addr (r_addr),
        .data (w_rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DIGIT;
            r_addr      <= '0;
            r_match     <= 1'b1;
            r_tries     <= TRIES_W'(MAX_TRIES);
            r_gr        <= 1'b0;
            r_rd        <= 1'b1;
            r_locked    <= 1'b0;
            r_reconfig  <= 1'b0;
            r_timer_en  <= 1'b0;
            r_load_pass <= '0;
            r_lock_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_digit     <= '0;
            r_rom_q     <= '0;
        end else begin
            case (r_state)
                ST_DIGIT: begin
                    if (bus.pwButton) begin
                        r_digit    <= bus.pw;
                        r_wait_cnt <= '0;
                        r_state    <= ST_ROMWAIT;
                    end
                end
                ST_ROMWAIT: begin
                    if (r_wait_cnt == WC_W'(ROM_LAT - 1)) begin
                        r_rom_q <= w_rom_data;
                        r_state <= ST_COMPARE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (r_digit != r_rom_q) r_match <= 1'b0;
                    r_state <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (r_addr == AW'(PW_LEN - 1)) begin
                        r_addr  <= '0;
                        r_state <= ST_PWCHECK;
                    end else begin
                        r_addr  <= r_addr + AW'(1);
                        r_state <= ST_DIGIT;
                    end
                end
                ST_PWCHECK: begin
                    r_match <= 1'b1;
                    if (r_match) begin
                        r_tries <= TRIES_W'(MAX_TRIES);
                        r_state <= ST_PASSED;
                    end else if (r_tries == TRIES_W'(1)) begin
                        r_tries    <= '0;
                        r_locked   <= 1'b1;
                        r_rd       <= 1'b1;
                        r_lock_cnt <= '0;
                        r_state    <= ST_LOCKOUT;
                    end else begin
                        r_tries <= r_tries - TRIES_W'(1);
                        r_state <= ST_DIGIT;
                    end
                end
                ST_LOCKOUT: begin
                    // locked rises on entry and falls on exit: exactly LOCK_CYCLES cycles high
                    if (r_lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
                        r_lock_cnt <= '0;
                        r_locked   <= 1'b0;
                        r_tries    <= TRIES_W'(MAX_TRIES);
                        r_state    <= ST_DIGIT;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + LC_W'(1);
                    end
                end
                ST_PASSED: begin
                    r_gr    <= 1'b1;
                    r_rd    <= 1'b0;
                    r_state <= ST_RECONFIG;
                end
                ST_RECONFIG: begin
                    r_reconfig <= bus.pwButton;
                    if (bus.pwButton) r_state <= ST_GAMEWAIT;
                end
                ST_GAMEWAIT: begin
                    r_reconfig <= 1'b0;
                    if (bus.pwButton) r_state <= ST_GAMESTART;
                end
                ST_GAMESTART: begin
                    r_timer_en <= 1'b1;
                    // Clear on the leaving edge so the gated loads never show outside GAMESTART
                    if (bus.finalTimeout) begin
                        r_load_pass <= '0;
                        r_state     <= ST_GAMEOVER;
                    end else begin
                        r_load_pass <= bus.loadP;
                    end
                end
                ST_GAMEOVER: begin
                    r_load_pass <= '0;
                    r_timer_en  <= 1'b0;
                    r_rd        <= 1'b1;
                    r_state     <= ST_RECONFIG;
                end
                default: r_state <= ST_DIGIT;
            endcase
        end
    end

    assign bus.loadPPass   = r_load_pass;
    assign bus.GR          = r_gr;
    assign bus.RD          = r_rd;
    assign bus.reconfig    = r_reconfig;
    assign bus.timerEnable = r_timer_en;
    assign bus.locked      = r_locked;
    assign bus.triesLeft   = r_tries;

endmodule

`default_nettype wire

// File: tb/tb_access_controller_lockout.sv
// ============================================================================
//  Module      : tb_access_controller_lockout
//  Description : Directed self-checking bench for access_controller_lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_access_controller_lockout;
    import access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    access_controller_lockout_if #(.DIGIT_W(4), .NUM_PLAYERS(2), .MAX_TRIES(3)) bus ();

    access_controller_lockout #(
        .DIGIT_W(4), .PW_LEN(4), .ROM_LAT(2), .MAX_TRIES(3),
        .LOCK_CYCLES(20), .NUM_PLAYERS(2), .PW_INIT(16'h1953)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {GR, RD, locked, reconfig, timerEnable, loadPPass[1:0], triesLeft[1:0]}
    function automatic logic [8:0] outs();
        return {bus.GR, bus.RD, bus.locked, bus.reconfig, bus.timerEnable,
                bus.loadPPass, bus.triesLeft};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.pwButton = 1'b0;
        bus.finalTimeout = 1'b0;
        bus.loadP = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] d);
        bus.pw = d;
        bus.pwButton = 1'b1;
        @(negedge clk);
        bus.pwButton = 1'b0;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        pulse(d);
        repeat (4) @(negedge clk);
    endtask

    task automatic enter_code(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int i = 3; i >= 0; i--) enter_digit(c[i*4 +: 4]);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (outs() !== 9'b0_1_0_0_0_00_11) begin
            bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 9'b0_1_0_0_0_00_11);
        end
        total++;
        if (dut.r_state !== ST_DIGIT || dut.r_addr !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dut.r_state, dut.r_addr);
        end
    endtask

    task automatic test_pass();
        logic early;
        do_reset();
        enter_digit(4'd3); enter_digit(4'd5); enter_digit(4'd9);
        pulse(4'd1);
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.GR !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL pass_gr_early got=1 exp=0"); end
        @(negedge clk);
        total++;
        if (outs() !== 9'b1_0_0_0_0_00_11) begin
            bad++; $display("FAIL pass_outs got=%b exp=%b", outs(), 9'b1_0_0_0_0_00_11);
        end
    endtask

    task automatic test_fail();
        do_reset();
        enter_code(16'h3592);
        total++;
        if (outs() !== 9'b0_1_0_0_0_00_10) begin
            bad++; $display("FAIL fail_outs got=%b exp=%b", outs(), 9'b0_1_0_0_0_00_10);
        end
        total++;
        if (dut.r_state !== ST_DIGIT || dut.r_addr !== 2'd0) begin
            bad++; $display("FAIL fail_state got=%0d/%0d exp=0/0", dut.r_state, dut.r_addr);
        end
        enter_code(16'h3591);
        total++;
        if (outs() !== 9'b1_0_0_0_0_00_11) begin
            bad++; $display("FAIL fail_then_pass got=%b exp=%b", outs(), 9'b1_0_0_0_0_00_11);
        end
    endtask

    task automatic test_lockout();
        logic dropped;
        do_reset();
        enter_code(16'h0000);
        enter_code(16'h3590);
        total++;
        if (bus.triesLeft !== 2'd1) begin
            bad++; $display("FAIL lock_tries1 got=%0d exp=1", bus.triesLeft);
        end
        enter_digit(4'd1); enter_digit(4'd1); enter_digit(4'd1);
        pulse(4'd1);
        repeat (4) @(negedge clk);
        total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL lock_early got=1 exp=0"); end
        @(negedge clk);
        total++;
        if (outs() !== 9'b0_1_1_0_0_00_00) begin
            bad++; $display("FAIL lock_enter got=%b exp=%b", outs(), 9'b0_1_1_0_0_00_00);
        end
        dropped = 1'b0;
        bus.pw = 4'd3;
        for (int i = 0; i < 19; i++) begin
            bus.pwButton = (i < 17);
            @(negedge clk);
            if (bus.locked !== 1'b1) dropped = 1'b1;
        end
        bus.pwButton = 1'b0;
        total++;
        if (dropped) begin bad++; $display("FAIL lock_hold got=0 exp=1 for 20 cycles"); end
        @(negedge clk);
        total++;
        if (outs() !== 9'b0_1_0_0_0_00_11) begin
            bad++; $display("FAIL lock_exit got=%b exp=%b", outs(), 9'b0_1_0_0_0_00_11);
        end
        enter_code(16'h3591);
        total++;
        if (outs() !== 9'b1_0_0_0_0_00_11) begin
            bad++; $display("FAIL lock_then_pass got=%b exp=%b", outs(), 9'b1_0_0_0_0_00_11);
        end
    endtask

    task automatic test_game();
        // Continues from the passed state left by the previous test
        bus.loadP = 2'b11;
        bus.finalTimeout = 1'b1;
        @(negedge clk);
        bus.finalTimeout = 1'b0;
        total++;
        if (bus.loadPPass !== 2'b00 || bus.timerEnable !== 1'b0) begin
            bad++; $display("FAIL game_idle got=%b/%b exp=00/0", bus.loadPPass, bus.timerEnable);
        end
        pulse(4'd0);
        total++;
        if (bus.reconfig !== 1'b1) begin bad++; $display("FAIL game_reconfig got=0 exp=1"); end
        bus.loadP = 2'b10;
        pulse(4'd0);
        @(negedge clk);
        total++;
        if (bus.loadPPass !== 2'b10 || bus.timerEnable !== 1'b1 || bus.reconfig !== 1'b0) begin
            bad++; $display("FAIL game_start got=%b/%b/%b exp=10/1/0",
                            bus.loadPPass, bus.timerEnable, bus.reconfig);
        end
        bus.loadP = 2'b01;
        @(negedge clk);
        total++;
        if (bus.loadPPass !== 2'b01) begin
            bad++; $display("FAIL game_follow got=%b exp=01", bus.loadPPass);
        end
        bus.finalTimeout = 1'b1;
        @(negedge clk);
        bus.finalTimeout = 1'b0;
        total++;
        if (bus.loadPPass !== 2'b00) begin
            bad++; $display("FAIL game_timeout_load got=%b exp=00", bus.loadPPass);
        end
        @(negedge clk);
        total++;
        if (outs() !== 9'b1_1_0_0_0_00_11 || dut.r_state !== ST_RECONFIG) begin
            bad++; $display("FAIL game_over got=%b/%0d exp=%b/%0d",
                            outs(), dut.r_state, 9'b1_1_0_0_0_00_11, ST_RECONFIG);
        end
        bus.loadP = 2'b00;
    endtask

    task automatic test_rst_mid();
        do_reset();
        enter_digit(4'd3); enter_digit(4'd5);
        pulse(4'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (outs() !== 9'b0_1_0_0_0_00_11 || dut.r_state !== ST_DIGIT || dut.r_addr !== 2'd0) begin
            bad++; $display("FAIL rst_mid got=%b/%0d/%0d exp=%b/0/0",
                            outs(), dut.r_state, dut.r_addr, 9'b0_1_0_0_0_00_11);
        end
        enter_code(16'h3591);
        total++;
        if (outs() !== 9'b1_0_0_0_0_00_11) begin
            bad++; $display("FAIL rst_mid_pass got=%b exp=%b", outs(), 9'b1_0_0_0_0_00_11);
        end
    endtask

    task automatic test_drop();
        do_reset();
        pulse(4'd3);
        pulse(4'd5); pulse(4'd5); pulse(4'd5);
        @(negedge clk);
        total++;
        if (dut.r_addr !== 2'd1 || dut.r_state !== ST_DIGIT) begin
            bad++; $display("FAIL drop_count got=%0d/%0d exp=1/0", dut.r_addr, dut.r_state);
        end
        enter_digit(4'd5); enter_digit(4'd9); enter_digit(4'd1);
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== 9'b1_0_0_0_0_00_11) begin
            bad++; $display("FAIL drop_pass got=%b exp=%b", outs(), 9'b1_0_0_0_0_00_11);
        end
    endtask

    initial begin
        bus.pwButton = 1'b0;
        bus.pw = 4'd0;
        bus.loadP = 2'b00;
        bus.finalTimeout = 1'b0;
        test_reset();
        test_pass();
        test_fail();
        test_lockout();
        test_game();
        test_rst_mid();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

`default_nettype wire
